control_hora: RTL and testbench

CONTROL_HORA -- requirements
Module: control_hora

---
 rtl/control_hora.sv | 268 ++++++++++++++++++++++++++
 tb/tb_control_hora.sv | 413 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/control_hora.sv
`default_nettype none
// ============================================================================
// Module      : control_hora
// Description : Time-keeping controller for an RTC. Periodically reads the
//               seconds/minutes/hours registers over a bus interface, lets the
//               user edit the time with four buttons, and writes the edited
//               time back followed by an automatic read-back.
//
//   Ports
//     reloj            in   system clock, rising edge
//     resetM           in   synchronous active-high reset
//     tick             in   one-cycle periodic refresh request
//     edit_req         in   one-cycle request to enter edit mode
//     commit           in   one-cycle request to write edited time
//     IN_bot_hora[3:0] in   level buttons: 0 right, 1 up, 2 left, 3 down
//     bus_done         in   one-cycle completion strobe from the bus
//     bus_start        out  one-cycle access start strobe
//     READ             out  1 = read access, 0 = write access
//     Selec_Demux_DD   out  3 seg, 4 min, 5 hora, 6 none, 7 edit display
//     Contador_pos_h   out  edit cursor: 0 seg, 1 min, 2 hora
//     enable_cont_hora out  one-cycle step enable for field under cursor
//     cont_dir         out  step direction, 1 = up, 0 = down
//     enable_cont_16   out  high while editing (blink counter enable)
//     busy             out  high in any bus-access state
//     error            out  sticky bus-timeout flag
//
//   Build option
//     CONTROL_HORA_WATCHDOG_EN : when defined, an access state that sees no
//     bus_done for 255 cycles returns to IDLE and sets error. Otherwise
//     accesses wait indefinitely and error is constant 0.
//
// Revision    : 1.0 - initial release
// ============================================================================
module control_hora (
    input  logic       reloj,
    input  logic       resetM,
    input  logic       tick,
    input  logic       edit_req,
    input  logic       commit,
    input  logic [3:0] IN_bot_hora,
    input  logic       bus_done,
    output logic       bus_start,
    output logic       READ,
    output logic [3:0] Selec_Demux_DD,
    output logic [1:0] Contador_pos_h,
    output logic       enable_cont_hora,
    output logic       cont_dir,
    output logic       enable_cont_16,
    output logic       busy,
    output logic       error
);

    localparam logic [2:0] c_st_idle    = 3'd0;
    localparam logic [2:0] c_st_rd_seg  = 3'd1;
    localparam logic [2:0] c_st_rd_min  = 3'd2;
    localparam logic [2:0] c_st_rd_hora = 3'd3;
    localparam logic [2:0] c_st_edit    = 3'd4;
    localparam logic [2:0] c_st_wr_seg  = 3'd5;
    localparam logic [2:0] c_st_wr_min  = 3'd6;
    localparam logic [2:0] c_st_wr_hora = 3'd7;

    logic [2:0] r_state;
    logic [2:0] w_next;
    logic       r_first;      // first cycle after a state change
    logic       r_pend_tick;
    logic       r_pend_edit;
    logic [3:0] r_btn_prev;
    logic [1:0] r_pos;

    logic       w_busy;
    logic       w_is_read;
    logic       w_timeout;
    logic       w_edit_act;
    logic [3:0] w_rise;
    logic       w_act_right;
    logic       w_act_left;
    logic       w_act_up;
    logic       w_act_down;

    assign w_busy    = (r_state != c_st_idle) && (r_state != c_st_edit);
    assign w_is_read = (r_state == c_st_rd_seg) || (r_state == c_st_rd_min) ||
                       (r_state == c_st_rd_hora);

    // Button actions: one per rising edge, fixed priority right > left >
    // up > down. Nothing acts in the commit cycle.
    assign w_edit_act  = (r_state == c_st_edit) && !commit;
    assign w_rise      = IN_bot_hora & ~r_btn_prev;
    assign w_act_right = w_edit_act && w_rise[0];
    assign w_act_left  = w_edit_act && !w_rise[0] && w_rise[2];
    assign w_act_up    = w_edit_act && !w_rise[0] && !w_rise[2] && w_rise[1];
    assign w_act_down  = w_edit_act && !w_rise[0] && !w_rise[2] && !w_rise[1] &&
                         w_rise[3];

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge reloj) begin
        if (resetM) begin
            r_state <= c_st_idle;
            r_first <= 1'b0;
        end else begin
            r_state <= w_next;
            r_first <= (w_next != r_state);
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next = r_state;
        case (r_state)
            c_st_idle: begin
                if (edit_req || r_pend_edit) begin
                    w_next = c_st_edit;
                end else if (tick || r_pend_tick) begin
                    w_next = c_st_rd_seg;
                end
            end
            c_st_rd_seg: begin
                if (bus_done)       w_next = c_st_rd_min;
                else if (w_timeout) w_next = c_st_idle;
            end
            c_st_rd_min: begin
                if (bus_done)       w_next = c_st_rd_hora;
                else if (w_timeout) w_next = c_st_idle;
            end
            c_st_rd_hora: begin
                if (bus_done || w_timeout) w_next = c_st_idle;
            end
            c_st_edit: begin
                if (commit) w_next = c_st_wr_seg;
            end
            c_st_wr_seg: begin
                if (bus_done)       w_next = c_st_wr_min;
                else if (w_timeout) w_next = c_st_idle;
            end
            c_st_wr_min: begin
                if (bus_done)       w_next = c_st_wr_hora;
                else if (w_timeout) w_next = c_st_idle;
            end
            c_st_wr_hora: begin
                if (bus_done || w_timeout) w_next = c_st_idle;
            end
            default: w_next = c_st_idle;
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic
    // ------------------------------------------------------------------
    always_comb begin
        bus_start      = 1'b0;
        READ           = 1'b1;
        Selec_Demux_DD = 4'd6;
        busy           = w_busy;
        enable_cont_16 = 1'b0;
        case (r_state)
            c_st_rd_seg: begin
                Selec_Demux_DD = 4'd3;
                bus_start      = r_first;
            end
            c_st_rd_min: begin
                Selec_Demux_DD = 4'd4;
                bus_start      = r_first;
            end
            c_st_rd_hora: begin
                Selec_Demux_DD = 4'd5;
                bus_start      = r_first;
            end
            c_st_wr_seg: begin
                Selec_Demux_DD = 4'd3;
                READ           = 1'b0;
                bus_start      = r_first;
            end
            c_st_wr_min: begin
                Selec_Demux_DD = 4'd4;
                READ           = 1'b0;
                bus_start      = r_first;
            end
            c_st_wr_hora: begin
                Selec_Demux_DD = 4'd5;
                READ           = 1'b0;
                bus_start      = r_first;
            end
            c_st_edit: begin
                Selec_Demux_DD = 4'd7;
                enable_cont_16 = 1'b1;
            end
            default: begin
            end
        endcase
        enable_cont_hora = w_act_up | w_act_down;
        cont_dir         = w_act_up;
    end

    assign Contador_pos_h = r_pos;

    // ------------------------------------------------------------------
    // Pending requests, button edge history and edit cursor
    // ------------------------------------------------------------------
    always_ff @(posedge reloj) begin
        if (resetM) begin
            r_btn_prev  <= 4'd0;
            r_pend_tick <= 1'b0;
            r_pend_edit <= 1'b0;
            r_pos       <= 2'd0;
        end else begin
            r_btn_prev <= IN_bot_hora;

            // Leaving IDLE consumes any pending tick, including the case
            // where edit wins and the refresh is dropped. Completion of the
            // write sequence requests the read-back.
            if ((r_state == c_st_idle) && (w_next != c_st_idle)) begin
                r_pend_tick <= 1'b0;
            end else if (w_busy && (tick || ((r_state == c_st_wr_hora) && bus_done))) begin
                r_pend_tick <= 1'b1;
            end

            if ((r_state == c_st_idle) && (w_next == c_st_edit)) begin
                r_pend_edit <= 1'b0;
            end else if (w_is_read && edit_req) begin
                r_pend_edit <= 1'b1;
            end

            if (r_state == c_st_edit) begin
                if (commit) begin
                    r_pos <= 2'd0;
                end else if (w_act_right) begin
                    r_pos <= (r_pos == 2'd2) ? 2'd0 : r_pos + 2'd1;
                end else if (w_act_left) begin
                    r_pos <= (r_pos == 2'd0) ? 2'd2 : r_pos - 2'd1;
                end
            end
        end
    end

`ifdef CONTROL_HORA_WATCHDOG_EN
    logic [7:0] r_wdog;
    logic       r_error;

    // Counter restarts on every state change, so each access gets its own
    // 255-cycle window; the timeout fires in the 255th cycle.
    assign w_timeout = w_busy && (r_wdog == 8'd254) && !bus_done;
    assign error     = r_error;

    always_ff @(posedge reloj) begin
        if (resetM) begin
            r_wdog  <= 8'd0;
            r_error <= 1'b0;
        end else begin
            if ((w_next != r_state) || !w_busy) begin
                r_wdog <= 8'd0;
            end else begin
                r_wdog <= r_wdog + 8'd1;
            end
            if (w_timeout) begin
                r_error <= 1'b1;
            end
        end
    end
`else
    assign w_timeout = 1'b0;
    assign error     = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_control_hora.sv
`default_nettype none
// ============================================================================
// Module      : tb_control_hora
// Description : Scoreboard bench for control_hora. Stimulus pushes expected
//               bus accesses, step pulses and cursor values into queues; a
//               monitor pops and compares whenever the DUT presents them.
//               A responder process answers each bus_start after a random
//               latency and injects stray bus_done pulses when idle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_control_hora;

    logic       reloj = 1'b0;
    logic       resetM;
    logic       tick;
    logic       edit_req;
    logic       commit;
    logic [3:0] IN_bot_hora;
    logic       bus_done;
    logic       bus_start;
    logic       READ;
    logic [3:0] Selec_Demux_DD;
    logic [1:0] Contador_pos_h;
    logic       enable_cont_hora;
    logic       cont_dir;
    logic       enable_cont_16;
    logic       busy;
    logic       error;

    control_hora dut (
        .reloj            (reloj),
        .resetM           (resetM),
        .tick             (tick),
        .edit_req         (edit_req),
        .commit           (commit),
        .IN_bot_hora      (IN_bot_hora),
        .bus_done         (bus_done),
        .bus_start        (bus_start),
        .READ             (READ),
        .Selec_Demux_DD   (Selec_Demux_DD),
        .Contador_pos_h   (Contador_pos_h),
        .enable_cont_hora (enable_cont_hora),
        .cont_dir         (cont_dir),
        .enable_cont_16   (enable_cont_16),
        .busy             (busy),
        .error            (error)
    );

    always #5 reloj = ~reloj;

    int checks = 0;
    int errors = 0;
    int exp_acc[$];   // sel*2 + read
    int exp_adj[$];   // expected cont_dir per step pulse
    int exp_pos[$];   // expected cursor after each change
    int m_pos = 0;    // reference cursor
    bit no_resp = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic fail_timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s actual=timeout required=event within bound", name);
    endtask

    function automatic void push_seq(input bit rd);
        for (int s = 3; s <= 5; s++) exp_acc.push_back(s * 2 + (rd ? 1 : 0));
    endfunction

    task automatic cyc();
        @(posedge reloj);
        #1;
    endtask

    // ------------------------------------------------------------------
    // Bus responder
    // ------------------------------------------------------------------
    initial begin
        bit again;
        int lat;
        bus_done = 1'b0;
        forever begin
            @(posedge reloj);
            #2;
            again = 1'b1;
            while (again) begin
                again = 1'b0;
                if (bus_start && !resetM && !no_resp) begin
                    lat = $urandom_range(1, 6);
                    repeat (lat) @(posedge reloj);
                    #1 bus_done = 1'b1;
                    @(posedge reloj);
                    #1 bus_done = 1'b0;
                    #1;
                    again = 1'b1;
                end else if (!busy && !resetM && !no_resp && ($urandom_range(0, 7) == 0)) begin
                    bus_done = 1'b1;
                    @(posedge reloj);
                    #1 bus_done = 1'b0;
                    #1;
                    again = 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Monitor / scoreboard
    // ------------------------------------------------------------------
    initial begin
        logic       prev_bs;
        logic [1:0] prev_pos;
        logic [3:0] cur_sel;
        logic       cur_rd;
        int         e;
        prev_bs  = 1'b0;
        prev_pos = 2'd0;
        cur_sel  = 4'd6;
        cur_rd   = 1'b1;
        forever begin
            @(negedge reloj);
            if (resetM) begin
                prev_bs  = 1'b0;
                prev_pos = 2'd0;
            end else begin
                if (bus_start) begin
                    check("bus_start_one_cycle", prev_bs, 0);
                    check("busy_at_start", busy, 1);
`ifndef CONTROL_HORA_WATCHDOG_EN
                    check("error_tied_low", error, 0);
`endif
                    if (exp_acc.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL access_unexpected actual sel=%0d read=%0d required=none",
                                 Selec_Demux_DD, READ);
                    end else begin
                        e = exp_acc.pop_front();
                        check("access_sel", Selec_Demux_DD, e >> 1);
                        check("access_read", READ, e & 1);
                    end
                    cur_sel = Selec_Demux_DD;
                    cur_rd  = READ;
                end else if (busy) begin
                    check("sel_held", Selec_Demux_DD, cur_sel);
                    check("read_held", READ, cur_rd);
                end
                prev_bs = bus_start;

                if (enable_cont_hora) begin
                    check("step_in_edit", enable_cont_16, 1);
                    if (exp_adj.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL step_unexpected actual dir=%0d required=none", cont_dir);
                    end else begin
                        e = exp_adj.pop_front();
                        check("step_dir", cont_dir, e);
                    end
                end

                if (Contador_pos_h != prev_pos) begin
                    check("cursor_not3", (Contador_pos_h == 2'd3), 0);
                    if (exp_pos.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL cursor_unexpected actual=%0d required=none", Contador_pos_h);
                    end else begin
                        e = exp_pos.pop_front();
                        check("cursor", Contador_pos_h, e);
                    end
                    prev_pos = Contador_pos_h;
                end

                if (enable_cont_16) begin
                    check("edit_sel", Selec_Demux_DD, 7);
                    check("edit_not_busy", busy, 0);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic wait_idle(input string name);
        int run = 0;
        int n = 0;
        while (run < 3 && n < 3000) begin
            cyc();
            n++;
            if (!busy && Selec_Demux_DD == 4'd6 && !enable_cont_16) run++;
            else run = 0;
        end
        if (run < 3) fail_timeout(name);
    endtask

    task automatic wait_edit(input string name);
        int n = 0;
        while (!enable_cont_16 && n < 3000) begin
            cyc();
            n++;
        end
        if (!enable_cont_16) fail_timeout(name);
    endtask

    // Tick from IDLE, optionally followed by extra ticks and an edit_req
    // landing inside the read sequence.
    task automatic op_read(input int nticks, input bit ed);
        push_seq(1'b1);
        if (!ed && nticks > 0) push_seq(1'b1);
        tick = 1'b1;
        cyc();
        tick = 1'b0;
        repeat ($urandom_range(0, 1)) cyc();
        for (int i = 0; i < nticks; i++) begin
            tick = 1'b1;
            cyc();
            tick = 1'b0;
        end
        if (ed) begin
            edit_req = 1'b1;
            cyc();
            edit_req = 1'b0;
            wait_edit("enter_edit_pending");
        end else begin
            wait_idle("read_done");
        end
    endtask

    task automatic press(input logic [3:0] m, input int hold, input bit noise);
        if (m[0]) begin
            m_pos = (m_pos + 1) % 3;
            exp_pos.push_back(m_pos);
        end else if (m[2]) begin
            m_pos = (m_pos + 2) % 3;
            exp_pos.push_back(m_pos);
        end else if (m[1]) begin
            exp_adj.push_back(1);
        end else if (m[3]) begin
            exp_adj.push_back(0);
        end
        IN_bot_hora = m;
        for (int i = 0; i < hold; i++) begin
            if (noise) begin
                tick     = ($urandom_range(0, 3) == 0);
                edit_req = ($urandom_range(0, 3) == 0);
            end
            cyc();
        end
        IN_bot_hora = 4'd0;
        tick        = 1'b0;
        edit_req    = 1'b0;
        repeat ($urandom_range(1, 3)) cyc();
    endtask

    task automatic commit_seq(input bit with_btn);
        push_seq(1'b0);
        push_seq(1'b1);
        if (m_pos != 0) exp_pos.push_back(0);
        m_pos = 0;
        commit = 1'b1;
        if (with_btn) IN_bot_hora = 4'($urandom_range(1, 15));
        cyc();
        commit = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick     = 1'($urandom_range(0, 1));
            edit_req = 1'($urandom_range(0, 1));
            cyc();
        end
        tick        = 1'b0;
        edit_req    = 1'b0;
        IN_bot_hora = 4'd0;
        wait_idle("write_readback_done");
    endtask

    task automatic edit_from_idle();
        edit_req = 1'b1;
        tick     = 1'($urandom_range(0, 1));
        cyc();
        edit_req = 1'b0;
        tick     = 1'b0;
        wait_edit("enter_edit_idle");
    endtask

    task automatic random_session();
        repeat ($urandom_range(1, 6))
            press(4'($urandom_range(1, 15)), $urandom_range(1, 10), 1'b1);
        commit_seq(1'($urandom_range(0, 1)));
    endtask

    // ------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------
    initial begin
        resetM      = 1'b1;
        tick        = 1'b0;
        edit_req    = 1'b0;
        commit      = 1'b0;
        IN_bot_hora = 4'd0;
        repeat (3) cyc();
        check("rst_bus_start", bus_start, 0);
        check("rst_read", READ, 1);
        check("rst_sel", Selec_Demux_DD, 6);
        check("rst_pos", Contador_pos_h, 0);
        check("rst_enable", enable_cont_hora, 0);
        check("rst_dir", cont_dir, 0);
        check("rst_en16", enable_cont_16, 0);
        check("rst_busy", busy, 0);
        check("rst_error", error, 0);
        resetM = 1'b0;
        cyc();

        // Plain refresh
        op_read(0, 1'b0);

        // Directed edit: right, right, left, up held, down held, commit
        edit_from_idle();
        press(4'h1, 4, 1'b0);
        press(4'h1, 4, 1'b0);
        press(4'h4, 4, 1'b0);
        press(4'h2, 10, 1'b0);
        press(4'h8, 10, 1'b0);
        commit_seq(1'b0);

        // Two ticks plus edit_req during a read
        op_read(2, 1'b1);
        random_session();

        for (int it = 0; it < 25; it++) begin
            case ($urandom_range(0, 2))
                0: op_read($urandom_range(0, 2), 1'b0);
                1: begin
                    op_read($urandom_range(0, 2), 1'b1);
                    random_session();
                end
                default: begin
                    edit_from_idle();
                    random_session();
                end
            endcase
        end

        // Reset in the middle of a read with a tick already pending
        push_seq(1'b1);
        void'(exp_acc.pop_back());
        void'(exp_acc.pop_back());
        tick = 1'b1;
        cyc();
        tick = 1'b1;
        cyc();
        tick   = 1'b0;
        resetM = 1'b1;
        cyc();
        resetM = 1'b0;
        for (int i = 0; i < 10; i++) begin
            check("abort_no_start", bus_start, 0);
            check("abort_idle", busy, 0);
            cyc();
        end
        check("abort_sel", Selec_Demux_DD, 6);

`ifdef CONTROL_HORA_WATCHDOG_EN
        begin
            int n;
            no_resp = 1'b1;
            repeat (10) cyc();
            push_seq(1'b1);
            void'(exp_acc.pop_back());
            void'(exp_acc.pop_back());
            tick = 1'b1;
            cyc();
            tick = 1'b0;
            n = 0;
            while (busy && n < 400) begin
                n++;
                cyc();
            end
            check("wdog_cycles", n, 255);
            check("wdog_error", error, 1);
            check("wdog_sel", Selec_Demux_DD, 6);
            resetM = 1'b1;
            cyc();
            resetM = 1'b0;
            check("wdog_error_cleared", error, 0);
            no_resp = 1'b0;
        end
`endif

        repeat (10) cyc();
        check("acc_queue_empty", exp_acc.size(), 0);
        check("step_queue_empty", exp_adj.size(), 0);
        check("cursor_queue_empty", exp_pos.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #800000;
        $display("FAIL global_timeout actual=no finish required=finish");
        $fatal(1, "bench timeout");
    end

endmodule
`default_nettype wire
